// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames one byte per request onto a UART line, paced by an external baud clock.
//   clock, reset         system clock, asynchronous active-high reset
//   baud_clk             baud level from the generator, synchronized internally
//   tx_start, tx_data    request and byte, latched in the accepting cycle
//   parity_en/odd, stop_2 frame format, latched with the byte
//   tx_out               serial line, idle high
//   tx_busy, tx_done     frame in flight / one-cycle end-of-frame pulse
module uart_tx_serializer #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop_2,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t               state;
    logic                 sync1, sync2, sync_d;
    logic                 baud_tick;
    logic [DATA_BITS-1:0] data_r;
    logic                 pe_r, po_r, s2_r;
    logic [IW-1:0]        idx;

    assign baud_tick = sync2 & ~sync_d;

    // ALIGN absorbs the arbitrary phase between acceptance and the next baud edge,
    // so every line bit lasts exactly one tick period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync_d  <= 1'b0;
            state   <= IDLE;
            data_r  <= '0;
            pe_r    <= 1'b0;
            po_r    <= 1'b0;
            s2_r    <= 1'b0;
            idx     <= '0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            sync1   <= baud_clk;
            sync2   <= sync1;
            sync_d  <= sync2;
            tx_done <= 1'b0;
            case (state)
                IDLE: if (tx_start) begin
                    data_r  <= tx_data;
                    pe_r    <= parity_en;
                    po_r    <= parity_odd;
                    s2_r    <= stop_2;
                    tx_busy <= 1'b1;
                    state   <= ALIGN;
                end
                ALIGN: if (baud_tick) begin
                    tx_out <= 1'b0;
                    state  <= START;
                end
                START: if (baud_tick) begin
                    idx    <= '0;
                    tx_out <= data_r[0];
                    state  <= DATA;
                end
                DATA: if (baud_tick) begin
                    if (idx == LAST) begin
                        tx_out <= pe_r ? (^data_r ^ po_r) : 1'b1;
                        state  <= pe_r ? PARITY : STOP1;
                    end else begin
                        idx    <= idx + 1'b1;
                        tx_out <= data_r[idx + 1'b1];
                    end
                end
                PARITY: if (baud_tick) begin
                    tx_out <= 1'b1;
                    state  <= STOP1;
                end
                STOP1: if (baud_tick) begin
                    state   <= s2_r ? STOP2 : IDLE;
                    tx_busy <= s2_r;
                    tx_done <= ~s2_r;
                end
                STOP2: if (baud_tick) begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame vectors and corner-case sequences for uart_tx_serializer.
module tb_uart_tx_serializer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       baud_clk = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       stop_2 = 1'b0;
    logic       tx_out, tx_busy, tx_done;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        po;
        logic        s2;
        logic [11:0] frame;
        int          len;
        logic        poke;
    } vec_t;

    vec_t vecs[6];

    uart_tx_serializer dut (
        .clock(clock), .reset(reset), .baud_clk(baud_clk), .tx_start(tx_start),
        .tx_data(tx_data), .parity_en(parity_en), .parity_odd(parity_odd), .stop_2(stop_2),
        .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clock = ~clock;

    always begin
        repeat (8) @(negedge clock);
        baud_clk = ~baud_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_low(output int n);
        n = 0;
        while (tx_out !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        check("start_bit_seen", 32'(n < 40), 1);
    endtask

    task automatic capture(input logic [11:0] frame, input int len, input logic poke);
        int n;
        wait_low(n);
        repeat (8) step();
        for (int i = 0; i < len; i++) begin
            check($sformatf("line_bit%0d", i), 32'(tx_out), 32'(frame[i]));
            if (i < len - 1) begin
                if (poke && i == 5) begin
                    tx_start = 1'b1;
                    step();
                    tx_start = 1'b0;
                    repeat (15) step();
                end else begin
                    repeat (16) step();
                end
            end
        end
    endtask

    task automatic finish_frame(input logic held);
        int n = 0;
        while (tx_done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check("done_delay", n, 8);
        check("busy_at_done", 32'(tx_busy), 0);
        if (!held) begin
            step();
            check("done_single", 32'(tx_done), 0);
            check("busy_after", 32'(tx_busy), 0);
            check("line_idle", 32'(tx_out), 1);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        tx_data = v.data; parity_en = v.pe; parity_odd = v.po; stop_2 = v.s2;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        tx_data = ~v.data; parity_en = ~v.pe; parity_odd = ~v.po; stop_2 = ~v.s2;
        check("busy_accept", 32'(tx_busy), 1);
        capture(v.frame, v.len, v.poke);
        finish_frame(1'b0);
    endtask

    initial begin
        int   n;
        vec_t v;
        // frame bit 0 = start, then data LSB-first, [parity], stop(s)
        vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 12'h60E, 11, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 12'h40E, 11, 1'b0};
        vecs[3] = '{8'hA3, 1'b0, 1'b0, 1'b1, 12'h746, 11, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 12'hDFE, 12, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 12'h600, 11, 1'b0};

        tx_start = 1'b1;
        tx_data = 8'hFF;
        #3 reset = 1'b1;
        repeat (3) step();
        check("rst_tx_out", 32'(tx_out), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_done", 32'(tx_done), 0);
        @(negedge clock);
        tx_start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (20) step();
        check("post_rst_busy", 32'(tx_busy), 0);
        check("post_rst_line", 32'(tx_out), 1);

        for (int i = 0; i < 6; i++) apply(vecs[i]);

        // back-to-back with tx_start held across tx_done
        @(negedge clock);
        tx_data = 8'h3C; parity_en = 1'b0; parity_odd = 1'b0; stop_2 = 1'b0;
        tx_start = 1'b1;
        @(negedge clock);
        tx_data = 8'hC5;
        capture(12'h278, 10, 1'b0);
        finish_frame(1'b1);
        wait_low(n);
        check("b2b_gap", n, 16);
        tx_start = 1'b0;
        capture(12'h38A, 10, 1'b0);
        finish_frame(1'b0);

        // reset during data bit 4
        @(negedge clock);
        tx_data = 8'hE5; tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        capture(12'h3CA, 6, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_line", 32'(tx_out), 1);
        check("async_rst_busy", 32'(tx_busy), 0);
        check("async_rst_done", 32'(tx_done), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        v = '{8'h81, 1'b0, 1'b0, 1'b0, 12'h302, 10, 1'b0};
        apply(v);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
